// File: rtl/down_counter_pkg.sv
// Shared counter definitions: FSM states and the default count width
// common to the up- and down-counters in the counter/timer chain.
package down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_counter_dff_en.sv
// WIDTH-bit register with asynchronous active-low reset and a load enable.
module dff_en #(
    parameter int unsigned WIDTH = down_counter_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_q;

    // Capture d on enabled edges; reset clears to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= '0;
        end else if (en) begin
            d_q <= d;
        end
    end

    assign q = d_q;

endmodule

// File: rtl/down_counter.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// Load has top priority; the count never wraps below zero.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             c,
    input  logic             rn,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc
);

    state_t           state_q, state_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             cnt_en;
    logic [WIDTH-1:0] rld_q;
    logic             rld_en;

    // Count register.
    dff_en #(.WIDTH(WIDTH)) u_cnt (
        .clk   (c),
        .rst_n (rn),
        .en    (cnt_en),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    // Reload value register, written only on load.
    dff_en #(.WIDTH(WIDTH)) u_rld (
        .clk   (c),
        .rst_n (rn),
        .en    (rld_en),
        .d     (ld_val),
        .q     (rld_q)
    );

    // State and terminal-count flops.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state_q <= IDLE;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    // Next-state, decrement and reload selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_en  = 1'b0;
        rld_en  = 1'b0;
        tc_d    = 1'b0;
        if (ld) begin
            cnt_d   = ld_val;
            cnt_en  = 1'b1;
            rld_en  = 1'b1;
            state_d = RUN;
        end else if (state_q == RUN && en) begin
            if (cnt_q != '0) begin
                cnt_d  = cnt_q - WIDTH'(1);
                cnt_en = 1'b1;
            end else begin
                tc_d = 1'b1;
                if (reload) begin
                    cnt_d  = rld_q;
                    cnt_en = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    assign q    = cnt_q;
    assign busy = (state_q == RUN);
    assign tc   = tc_q;

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down-counter: the counting-down counterpart of the team's 3-bit up-counter (q1 MSB .. q3 LSB).
- Counts from a loaded value to 0 and flags terminal count with a one-cycle pulse.
- Optional auto-reload makes it a periodic divider/timer.
- Sits beside the up-counter in the counter/timer chain and consumes the same WIDTH-bit count format.

Parameters:
- WIDTH, 3, counter width in bits; the q output is MSB-first, matching the up-counter's q1..q3 ordering.

Ports:
- c  input  1  clock; all state changes on the rising edge.
- rn  input  1  reset, asynchronous, active-low.
- ld  input  1  load strobe, sampled on the rising edge.
- ld_val  input  WIDTH  value captured when ld=1.
- en  input  1  count enable; 0 pauses the count (q holds).
- reload  input  1  auto-reload mode; sampled at terminal count.
- q  output  WIDTH  current count, registered.
- busy  output  1  1 while in RUN, registered.
- tc  output  1  terminal-count pulse, registered, exactly one cycle wide.

Behaviour:
- Clock and reset: one clock `c`. Reset `rn` is asynchronous and active-low. While rn=0: q=0, busy=0, tc=0, stored reload value=0, state=IDLE. Release takes effect at the first rising edge with rn=1.
- State machine has two states, IDLE and RUN; busy = (state==RUN). The state encoding is internal.
- ld=1, any state, highest priority:
  - q<=ld_val, reload register<=ld_val, state<=RUN, tc<=0.
  - en is ignored on that edge. A load latency of one edge (q shows ld_val after the edge).
  - A load mid-run restarts the count and suppresses any tc that the same edge would have produced.
- IDLE, ld=0: q holds its value, tc<=0. en has no effect.
- RUN, ld=0, en=0: q holds, state holds, tc<=0.
- RUN, ld=0, en=1, q>0: q<=q-1, tc<=0.
- RUN, ld=0, en=1, q==0 (terminal): tc<=1 for exactly the next cycle.
  - If reload=1: q<=reload register, state stays RUN.
  - If reload=0: q stays 0, state<=IDLE.
- Count sequence after loading N with en held at 1: N, N-1, .., 0. tc is high during the cycle after q shows 0.
  - Period in reload mode is N+1 cycles, with one tc per period.
  - N=0 is legal: tc on the second edge after the load.
  - N=2^WIDTH-1 gives a full 2^WIDTH period, mirroring the up-counter's 7->0 wrap.
- q never underflows: the decrement happens only when q>0, so there is no wrap from 0 to all-ones.
- Mid-operation reset is asynchronous and immediate. No tc is emitted, and the count is lost.
- tc never stays high for two consecutive cycles unless reload=1 and N=0. In that case tc is high every cycle while en=1, which is legal.

Decomposition:
- Shared counter package holds:
  - the state constants IDLE/RUN;
  - default WIDTH=3, shared with the up-counter.
- One natural sub-module, `dff_en`: a WIDTH-bit register with async active-low reset and a load enable. It is instantiated for q and for the reload register.
- The FSM and next-state/decrement logic stay in down_counter.

Test Plan (WIDTH=3):
- Reset → q=0, busy=0, tc=0. ld=1, ld_val=5, en=1, reload=0 → q shows 5,4,3,2,1,0 on successive edges; tc=1 for one cycle after the 0; then busy=0 and q holds 0.
- ld_val=3, reload=1, en=1 for 12 edges → q shows 3,2,1,0,3,2,1,0,3,2,1,0; tc is pulsed every 4th cycle; busy stays 1.
- ld_val=6, en toggled 1,0,0,1,1 → q shows 5,5,5,4,3; tc stays 0.
- Load 2 and run to q=0; on the terminal edge assert ld=1, ld_val=4 → q=4, tc stays 0, busy=1.
- ld_val=0 with reload=0 → q=0, busy=1, then tc=1 and busy=0 on the next edge. ld_val=7 with reload=1 → period of 8 cycles.
- rn pulsed low asynchronously (between edges) at q=4 → q=0, busy=0, tc=0 immediately; edges while rn=0 change nothing.
